// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_exec_stage
// Brief    : Two-stage pipelined SLL/SRL/SRA/ROTR unit built around a single
//            5-level logical-right shifter, with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module shift_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_var,
  input  logic [4:0]       in_shamt,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);

  localparam logic [1:0]       c_op_sll  = 2'b00;
  localparam logic [1:0]       c_op_srl  = 2'b01;
  localparam logic [1:0]       c_op_sra  = 2'b10;
  localparam logic [1:0]       c_op_rotr = 2'b11;
  localparam logic [WIDTH-1:0] c_ones    = {WIDTH{1'b1}};

  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [4:0]       r_s1_amt;
  logic [WIDTH-1:0] r_s1_value;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_zero;

  logic             w_s2_load;
  logic             w_in_fire;
  logic [4:0]       w_in_amt;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_lsr;
  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] w_rot_hi;
  logic [WIDTH-1:0] w_result;
  logic             w_unused_rs;

  function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] f_lsr(input logic [WIDTH-1:0] x,
                                             input logic [4:0]       a);
    logic [WIDTH-1:0] s;
    s = x;
    if (a[4]) s = s >> 16;
    if (a[3]) s = s >> 8;
    if (a[2]) s = s >> 4;
    if (a[1]) s = s >> 2;
    if (a[0]) s = s >> 1;
    return s;
  endfunction

  assign w_s2_load   = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready    = !r_s1_valid || w_s2_load;
  assign w_in_fire   = in_valid && in_ready;
  assign w_in_amt    = in_var ? in_rs[4:0] : in_shamt;
  assign w_unused_rs = ^in_rs[WIDTH-1:5];

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_zero   = r_s2_zero;

  // Left shifts reuse the right shifter on a bit-reversed operand; the rotate's
  // upper copy is value << (32-amt), expressed the same way with amount -amt.
  always_comb begin
    w_base   = (r_s1_op == c_op_sll) ? f_rev(r_s1_value) : r_s1_value;
    w_lsr    = f_lsr(w_base, r_s1_amt);
    w_fill   = f_lsr(c_ones, r_s1_amt);
    w_rot_hi = f_rev(f_lsr(f_rev(r_s1_value), 5'd0 - r_s1_amt));
    w_result = w_lsr;
    case (r_s1_op)
      c_op_sll:  w_result = f_rev(w_lsr);
      c_op_srl:  w_result = w_lsr;
      c_op_sra:  w_result = w_lsr | (r_s1_value[WIDTH-1] ? ~w_fill : '0);
      c_op_rotr: w_result = (r_s1_amt == 5'd0) ? r_s1_value : (w_lsr | w_rot_hi);
      default:   w_result = w_lsr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= c_op_sll;
      r_s1_amt   <= 5'd0;
      r_s1_value <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= in_op;
      r_s1_amt   <= w_in_amt;
      r_s1_value <= in_value;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_zero   <= 1'b1;
    end else if (w_s2_load) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= w_result;
      r_s2_zero   <= (w_result == '0);
    end else if (out_ready) begin
      r_s2_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_exec_stage
// Brief    : Directed self-checking bench for shift_exec_stage.
// Revision : 1.0
// ============================================================================
module tb_shift_exec_stage;

  localparam logic [1:0] c_sll  = 2'b00;
  localparam logic [1:0] c_srl  = 2'b01;
  localparam logic [1:0] c_sra  = 2'b10;
  localparam logic [1:0] c_rotr = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_var;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;

  int tests = 0;
  int fails = 0;

  shift_exec_stage #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_var     (in_var),
    .in_shamt   (in_shamt),
    .in_rs      (in_rs),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic vr,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] val);
    in_valid = v;
    in_op    = op;
    in_var   = vr;
    in_shamt = sh;
    in_rs    = rs;
    in_value = val;
  endtask

  // Present one op at a negedge, then check the 2-edge latency and the result.
  task automatic run_single(input string tag, input logic [1:0] op, input logic vr,
                            input logic [4:0] sh, input logic [31:0] rs,
                            input logic [31:0] val, input logic [31:0] exp);
    drive(1'b1, op, vr, sh, rs, val);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    drive(1'b0, c_sll, 1'b0, 5'd0, 32'd0, 32'd0);
    check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, exp);
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, c_sll, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    check("rst_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_zero",   {31'd0, out_zero}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_single("srl4",     c_srl,  1'b0, 5'd4,  32'd0,        32'h8000_0000, 32'h0800_0000);
    run_single("sra4",     c_sra,  1'b0, 5'd4,  32'd0,        32'h8000_0000, 32'hF800_0000);
    run_single("sra31n",   c_sra,  1'b0, 5'd31, 32'd0,        32'h8000_0000, 32'hFFFF_FFFF);
    run_single("sra31p",   c_sra,  1'b0, 5'd31, 32'd0,        32'h7FFF_FFFF, 32'h0000_0000);
    run_single("sll31",    c_sll,  1'b0, 5'd31, 32'd0,        32'h0000_0001, 32'h8000_0000);
    run_single("sllv",     c_sll,  1'b1, 5'd0,  32'hFFFF_FFE3, 32'h0000_0001, 32'h0000_0008);
    run_single("srlv",     c_srl,  1'b1, 5'd0,  32'h0000_0024, 32'hF000_0000, 32'h0F00_0000);
    run_single("rotr8",    c_rotr, 1'b0, 5'd8,  32'd0,        32'h1234_5678, 32'h7812_3456);
    run_single("rotr0",    c_rotr, 1'b0, 5'd0,  32'd0,        32'h1234_5678, 32'h1234_5678);
    run_single("rotrv31",  c_rotr, 1'b1, 5'd5,  32'hFFFF_FFFF, 32'h1234_5678, 32'h2468_ACF0);
    run_single("sll0",     c_sll,  1'b0, 5'd0,  32'd0,        32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_single("sra0",     c_sra,  1'b0, 5'd0,  32'd0,        32'h8000_0001, 32'h8000_0001);
    @(negedge clock);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back with the sink stalled: A,B fill the pipe, C,D wait.
    out_ready = 1'b0;
    drive(1'b1, c_srl, 1'b0, 5'd4, 32'd0, 32'h0000_00F0);
    check("bb_a_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    drive(1'b1, c_sll, 1'b0, 5'd8, 32'd0, 32'h0000_0003);
    check("bb_b_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    drive(1'b1, c_sra, 1'b0, 5'd1, 32'd0, 32'h8000_0000);
    check("bb_full_ready", {31'd0, in_ready}, 32'd0);
    check("bb_stall_a1", out_result, 32'h0000_000F);
    @(negedge clock);
    check("bb_full_ready2", {31'd0, in_ready}, 32'd0);
    check("bb_stall_valid", {31'd0, out_valid}, 32'd1);
    check("bb_stall_a2", out_result, 32'h0000_000F);
    out_ready = 1'b1;
    #1;
    check("bb_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    check("bb_res_b", out_result, 32'h0000_0300);
    drive(1'b1, c_rotr, 1'b0, 5'd1, 32'd0, 32'h0000_0001);
    check("bb_d_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    drive(1'b0, c_sll, 1'b0, 5'd0, 32'd0, 32'd0);
    check("bb_res_c", out_result, 32'hC000_0000);
    check("bb_res_c_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    check("bb_res_d", out_result, 32'h8000_0000);
    check("bb_res_d_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    check("bb_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two ops in flight, while a new op is being offered.
    out_ready = 1'b0;
    drive(1'b1, c_srl, 1'b0, 5'd1, 32'd0, 32'h0000_0010);
    @(negedge clock);
    drive(1'b1, c_srl, 1'b0, 5'd2, 32'd0, 32'h0000_0010);
    @(negedge clock);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    drive(1'b1, c_sll, 1'b0, 5'd1, 32'd0, 32'h0000_0001);
    @(negedge clock);
    check("mrst_valid",  {31'd0, out_valid}, 32'd0);
    check("mrst_result", out_result, 32'd0);
    check("mrst_zero",   {31'd0, out_zero}, 32'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, c_sll, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clock);
    check("mrst_ready",   {31'd0, in_ready}, 32'd1);
    check("mrst_nostale", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("mrst_nostale2", {31'd0, out_valid}, 32'd0);
    run_single("post_rst", c_srl, 1'b0, 5'd31, 32'd0, 32'h8000_0000, 32'h0000_0001);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
